// File: rtl/luma_filter_8tap.sv
// Multi-flux 8-tap luma filter: loads one tagged coefficient set, runs eight
// serial MACs on that tag's reference samples, then rounds, shifts and clips.
module luma_filter_8tap #(
    parameter int FLUX         = 2,
    parameter int COEF_WIDTH   = 9,
    parameter int SAMPLE_WIDTH = 8,
    parameter int SHIFT        = 6,
    localparam int TAG_WIDTH   = $clog2(FLUX)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [COEF_WIDTH+TAG_WIDTH-1:0]   read_port_c0_dout,
    input  logic [FLUX-1:0]                   read_port_c0_empty,
    output logic [FLUX-1:0]                   read_port_c0_read,
    input  logic [COEF_WIDTH+TAG_WIDTH-1:0]   read_port_c1_dout,
    input  logic [FLUX-1:0]                   read_port_c1_empty,
    output logic [FLUX-1:0]                   read_port_c1_read,
    input  logic [COEF_WIDTH+TAG_WIDTH-1:0]   read_port_c2_dout,
    input  logic [FLUX-1:0]                   read_port_c2_empty,
    output logic [FLUX-1:0]                   read_port_c2_read,
    input  logic [COEF_WIDTH+TAG_WIDTH-1:0]   read_port_c3_dout,
    input  logic [FLUX-1:0]                   read_port_c3_empty,
    output logic [FLUX-1:0]                   read_port_c3_read,
    input  logic [COEF_WIDTH+TAG_WIDTH-1:0]   read_port_c4_dout,
    input  logic [FLUX-1:0]                   read_port_c4_empty,
    output logic [FLUX-1:0]                   read_port_c4_read,
    input  logic [COEF_WIDTH+TAG_WIDTH-1:0]   read_port_c5_dout,
    input  logic [FLUX-1:0]                   read_port_c5_empty,
    output logic [FLUX-1:0]                   read_port_c5_read,
    input  logic [COEF_WIDTH+TAG_WIDTH-1:0]   read_port_c6_dout,
    input  logic [FLUX-1:0]                   read_port_c6_empty,
    output logic [FLUX-1:0]                   read_port_c6_read,
    input  logic [COEF_WIDTH+TAG_WIDTH-1:0]   read_port_c7_dout,
    input  logic [FLUX-1:0]                   read_port_c7_empty,
    output logic [FLUX-1:0]                   read_port_c7_read,
    input  logic [SAMPLE_WIDTH+TAG_WIDTH-1:0] read_port_x_dout,
    input  logic [FLUX-1:0]                   read_port_x_empty,
    output logic [FLUX-1:0]                   read_port_x_read,
    output logic [SAMPLE_WIDTH+TAG_WIDTH-1:0] write_port_y_din,
    input  logic [FLUX-1:0]                   write_port_y_full,
    output logic                              write_port_y_write
);

    localparam int CW         = COEF_WIDTH + TAG_WIDTH;
    localparam int XW         = SAMPLE_WIDTH + TAG_WIDTH;
    localparam int PROD_WIDTH = COEF_WIDTH + SAMPLE_WIDTH + 1;
    localparam int ACC_WIDTH  = COEF_WIDTH + SAMPLE_WIDTH + 4;
    localparam logic [ACC_WIDTH-1:0] ROUND = ACC_WIDTH'(1 << (SHIFT - 1));

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_t;

    state_t                                state_q, state_d;
    logic [2:0]                            idx_q, idx_d;
    logic signed [ACC_WIDTH-1:0]           acc_q, acc_d;
    logic [TAG_WIDTH-1:0]                  lock_tag_q, lock_tag_d;
    logic [7:0][COEF_WIDTH-1:0]            coef_q, coef_d;

    logic [7:0][CW-1:0]                    c_dout;
    logic [FLUX-1:0]                       c_avail;
    logic                                  grant_found;
    logic [TAG_WIDTH-1:0]                  grant_tag;
    logic [COEF_WIDTH-1:0]                 coef_sel;
    logic [SAMPLE_WIDTH-1:0]               x_sample;
    logic signed [PROD_WIDTH-1:0]          prod;
    logic signed [ACC_WIDTH-1:0]           prod_ext;
    logic signed [ACC_WIDTH-1:0]           rounded;
    logic signed [ACC_WIDTH-1:0]           shifted;
    logic [SAMPLE_WIDTH-1:0]               y_clip;
    logic [FLUX-1:0]                       c_read;
    logic [FLUX-1:0]                       x_read;
    logic                                  y_write;
    logic [XW-1:0]                         y_din;
    logic                                  unused_tag_bits;

    assign c_dout = {read_port_c7_dout, read_port_c6_dout, read_port_c5_dout,
                     read_port_c4_dout, read_port_c3_dout, read_port_c2_dout,
                     read_port_c1_dout, read_port_c0_dout};

    assign c_avail = ~(read_port_c0_empty | read_port_c1_empty | read_port_c2_empty |
                       read_port_c3_empty | read_port_c4_empty | read_port_c5_empty |
                       read_port_c6_empty | read_port_c7_empty);

    // Only c0 carries the authoritative tag; the rest must agree by construction.
    assign unused_tag_bits = ^{read_port_c1_dout[CW-1:COEF_WIDTH], read_port_c2_dout[CW-1:COEF_WIDTH],
                               read_port_c3_dout[CW-1:COEF_WIDTH], read_port_c4_dout[CW-1:COEF_WIDTH],
                               read_port_c5_dout[CW-1:COEF_WIDTH], read_port_c6_dout[CW-1:COEF_WIDTH],
                               read_port_c7_dout[CW-1:COEF_WIDTH], read_port_x_dout[XW-1:SAMPLE_WIDTH]};

    always_comb begin
        grant_found = 1'b0;
        grant_tag   = '0;
        for (int i = FLUX - 1; i >= 0; i--) begin
            if (c_avail[i]) begin
                grant_found = 1'b1;
                grant_tag   = TAG_WIDTH'(i);
            end
        end
    end

    always_comb begin
        coef_sel = coef_q[idx_q];
        x_sample = read_port_x_dout[SAMPLE_WIDTH-1:0];
        prod     = $signed({{(SAMPLE_WIDTH + 1){coef_sel[COEF_WIDTH-1]}}, coef_sel}) *
                   $signed({{COEF_WIDTH{1'b0}}, x_sample});
        prod_ext = {{(ACC_WIDTH - PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};
    end

    // Arithmetic shift floors negative sums; anything negative clips to 0.
    always_comb begin
        rounded = acc_q + $signed(ROUND);
        shifted = rounded >>> SHIFT;
        if (shifted[ACC_WIDTH-1]) begin
            y_clip = '0;
        end else if (|shifted[ACC_WIDTH-2:SAMPLE_WIDTH]) begin
            y_clip = '1;
        end else begin
            y_clip = shifted[SAMPLE_WIDTH-1:0];
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        acc_d      = acc_q;
        lock_tag_d = lock_tag_q;
        coef_d     = coef_q;
        c_read     = '0;
        x_read     = '0;
        y_write    = 1'b0;
        y_din      = '0;
        unique case (state_q)
            IDLE: begin
                if (grant_found) begin
                    c_read[grant_tag] = 1'b1;
                    for (int k = 0; k < 8; k++) begin
                        coef_d[k] = c_dout[k][COEF_WIDTH-1:0];
                    end
                    lock_tag_d = c_dout[0][CW-1:COEF_WIDTH];
                    acc_d      = '0;
                    idx_d      = '0;
                    state_d    = MAC;
                end
            end
            MAC: begin
                if (!read_port_x_empty[lock_tag_q]) begin
                    x_read[lock_tag_q] = 1'b1;
                    acc_d = acc_q + prod_ext;
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = OUT;
                    end
                end
            end
            OUT: begin
                y_din = {lock_tag_q, y_clip};
                if (!write_port_y_full[lock_tag_q]) begin
                    y_write = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            acc_q      <= '0;
            lock_tag_q <= '0;
            coef_q     <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            acc_q      <= acc_d;
            lock_tag_q <= lock_tag_d;
            coef_q     <= coef_d;
        end
    end

    // Strobes are silenced while reset is held so nothing is consumed then.
    assign read_port_c0_read  = rst ? '0 : c_read;
    assign read_port_c1_read  = rst ? '0 : c_read;
    assign read_port_c2_read  = rst ? '0 : c_read;
    assign read_port_c3_read  = rst ? '0 : c_read;
    assign read_port_c4_read  = rst ? '0 : c_read;
    assign read_port_c5_read  = rst ? '0 : c_read;
    assign read_port_c6_read  = rst ? '0 : c_read;
    assign read_port_c7_read  = rst ? '0 : c_read;
    assign read_port_x_read   = rst ? '0 : x_read;
    assign write_port_y_write = rst ? 1'b0 : y_write;
    assign write_port_y_din   = rst ? '0 : y_din;

endmodule

// File: tb/tb_luma_filter_8tap.sv
// Directed bench for luma_filter_8tap: FWFT FIFO models on every port, a write
// log, and hand-computed expected samples for each coefficient set.
module tb_luma_filter_8tap;

    typedef int vec8_t [8];

    logic       clk;
    logic       rst;
    logic [9:0] c_dout [8];
    logic [1:0] c_emp;
    logic [1:0] c_read [8];
    logic [8:0] x_dout;
    logic [1:0] x_emp;
    logic [1:0] x_read;
    logic [8:0] y_din;
    logic [1:0] y_full;
    logic       y_write;

    int c_set [2][16][8];
    int c_cnt [2] = '{0, 0};
    int c_ptr [2] = '{0, 0};
    int x_mem [2][128];
    int x_cnt [2] = '{0, 0};
    int x_ptr [2] = '{0, 0};
    int xr_n  [2] = '{0, 0};
    int wr_tag [32];
    int wr_y   [32];
    int wr_cyc [32];
    int wr_n    = 0;
    int crd_n   = 0;
    int crd_cyc = 0;
    int cyc     = 0;
    int cmis    = 0;
    int bad     = 0;
    int checks  = 0;
    int errors  = 0;

    luma_filter_8tap dut (
        .clk                (clk),
        .rst                (rst),
        .read_port_c0_dout  (c_dout[0]), .read_port_c0_empty (c_emp), .read_port_c0_read (c_read[0]),
        .read_port_c1_dout  (c_dout[1]), .read_port_c1_empty (c_emp), .read_port_c1_read (c_read[1]),
        .read_port_c2_dout  (c_dout[2]), .read_port_c2_empty (c_emp), .read_port_c2_read (c_read[2]),
        .read_port_c3_dout  (c_dout[3]), .read_port_c3_empty (c_emp), .read_port_c3_read (c_read[3]),
        .read_port_c4_dout  (c_dout[4]), .read_port_c4_empty (c_emp), .read_port_c4_read (c_read[4]),
        .read_port_c5_dout  (c_dout[5]), .read_port_c5_empty (c_emp), .read_port_c5_read (c_read[5]),
        .read_port_c6_dout  (c_dout[6]), .read_port_c6_empty (c_emp), .read_port_c6_read (c_read[6]),
        .read_port_c7_dout  (c_dout[7]), .read_port_c7_empty (c_emp), .read_port_c7_read (c_read[7]),
        .read_port_x_dout   (x_dout),
        .read_port_x_empty  (x_emp),
        .read_port_x_read   (x_read),
        .write_port_y_din   (y_din),
        .write_port_y_full  (y_full),
        .write_port_y_write (y_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign c_emp = {c_ptr[1] >= c_cnt[1], c_ptr[0] >= c_cnt[0]};
    assign x_emp = {x_ptr[1] >= x_cnt[1], x_ptr[0] >= x_cnt[0]};

    // FWFT heads: the tag presented follows whichever read bit the DUT raises.
    always_comb begin
        int csel;
        int xsel;
        csel = c_read[0][1] ? 1 : 0;
        xsel = x_read[1] ? 1 : 0;
        for (int k = 0; k < 8; k++) begin
            c_dout[k] = '0;
            if (c_ptr[csel] < c_cnt[csel]) begin
                c_dout[k] = {csel[0], 9'(c_set[csel][c_ptr[csel]][k])};
            end
        end
        x_dout = '0;
        if (x_ptr[xsel] < x_cnt[xsel]) begin
            x_dout = {xsel[0], 8'(x_mem[xsel][x_ptr[xsel]])};
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            for (int t = 0; t < 2; t++) begin
                if (c_read[0][t]) c_ptr[t] <= c_ptr[t] + 1;
                if (x_read[t]) begin
                    x_ptr[t] <= x_ptr[t] + 1;
                    xr_n[t]  <= xr_n[t] + 1;
                    if (x_ptr[t] >= x_cnt[t]) bad <= bad + 1;
                end
            end
            if (|c_read[0]) begin
                crd_n   <= crd_n + 1;
                crd_cyc <= cyc;
            end
            for (int k = 1; k < 8; k++) begin
                if (c_read[k] !== c_read[0]) cmis <= cmis + 1;
            end
            if (x_read == 2'b11 || c_read[0] == 2'b11) bad <= bad + 1;
            if (y_write) begin
                if (y_full[y_din[8]]) bad <= bad + 1;
                wr_tag[wr_n] <= int'(y_din[8]);
                wr_y[wr_n]   <= int'(y_din[7:0]);
                wr_cyc[wr_n] <= cyc;
                wr_n         <= wr_n + 1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", name, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int tag, input vec8_t cf, input vec8_t xs, input int nx);
        c_set[tag][c_cnt[tag]] = cf;
        c_cnt[tag]++;
        for (int i = 0; i < nx; i++) x_mem[tag][x_cnt[tag] + i] = xs[i];
        x_cnt[tag] += nx;
    endtask

    task automatic pushSamples(input int tag, input vec8_t xs, input int from, input int n);
        for (int i = 0; i < n; i++) x_mem[tag][x_cnt[tag] + i] = xs[from + i];
        x_cnt[tag] += n;
    endtask

    task automatic waitWrites(input int n, input string name);
        int k = 0;
        while (wr_n < n && k < 300) begin
            @(negedge clk);
            k++;
        end
        checkOutput(name, 32'(wr_n >= n), 32'd1);
    endtask

    task automatic waitXReads(input int tag, input int n, input string name);
        int k = 0;
        while (xr_n[tag] < n && k < 300) begin
            @(negedge clk);
            k++;
        end
        checkOutput(name, 32'(xr_n[tag] >= n), 32'd1);
    endtask

    initial begin
        int base_c;
        int base_x0;
        int base_x1;
        int base_w;
        vec8_t stall_x;
        rst    = 1'b1;
        y_full = 2'b00;
        stall_x = '{1, 2, 3, 4, 5, 6, 7, 8};

        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset c_read", 32'(c_read[0]), 32'd0);
        checkOutput("reset x_read", 32'(x_read), 32'd0);
        checkOutput("reset write", 32'(y_write), 32'd0);
        checkOutput("reset din", 32'(y_din), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("idle no read", 32'(c_read[0]), 32'd0);

        // Single centre tap of 64 passes x[3] = 13 straight through.
        base_c = crd_n;
        base_x0 = xr_n[0];
        applyStimulus(0, '{0, 0, 0, 64, 0, 0, 0, 0}, '{10, 11, 12, 13, 14, 15, 16, 17}, 8);
        waitWrites(1, "t1 write");
        checkOutput("t1 tag", 32'(wr_tag[0]), 32'd0);
        checkOutput("t1 y", 32'(wr_y[0]), 32'd13);
        checkOutput("t1 c-read cycles", 32'(crd_n - base_c), 32'd1);
        checkOutput("t1 x reads", 32'(xr_n[0] - base_x0), 32'd8);
        checkOutput("t1 latency", 32'(wr_cyc[0] - crd_cyc), 32'd9);

        // Tag 1: flat 100 -> 100, peaked 80*255 -> 319 -> 255, negative -4080 -> -64 -> 0.
        base_x0 = xr_n[0];
        applyStimulus(1, '{-1, 4, -11, 40, 40, -11, 4, -1}, '{100, 100, 100, 100, 100, 100, 100, 100}, 8);
        applyStimulus(1, '{-1, 4, -11, 40, 40, -11, 4, -1}, '{0, 0, 0, 255, 255, 0, 0, 0}, 8);
        applyStimulus(1, '{-1, 4, -11, 40, 40, -11, 4, -1}, '{255, 255, 255, 0, 0, 255, 255, 255}, 8);
        waitWrites(4, "t2 writes");
        checkOutput("t2a tag", 32'(wr_tag[1]), 32'd1);
        checkOutput("t2a y", 32'(wr_y[1]), 32'd100);
        checkOutput("t2b y clip high", 32'(wr_y[2]), 32'd255);
        checkOutput("t2c y clip low", 32'(wr_y[3]), 32'd0);
        checkOutput("t2c tag", 32'(wr_tag[3]), 32'd1);
        checkOutput("t2 no tag0 x reads", 32'(xr_n[0] - base_x0), 32'd0);

        // Both tags ready together: tag 0 must run first on its own samples.
        base_x0 = xr_n[0];
        base_x1 = xr_n[1];
        applyStimulus(1, '{-1, 4, -11, 40, 40, -11, 4, -1}, '{100, 100, 100, 100, 100, 100, 100, 100}, 8);
        applyStimulus(0, '{0, 0, 0, 64, 0, 0, 0, 0}, '{20, 21, 22, 23, 24, 25, 26, 27}, 8);
        waitWrites(5, "t3 first write");
        checkOutput("t3 first tag", 32'(wr_tag[4]), 32'd0);
        checkOutput("t3 first y", 32'(wr_y[4]), 32'd23);
        checkOutput("t3 tag1 x untouched", 32'(xr_n[1] - base_x1), 32'd0);
        checkOutput("t3 tag0 x reads", 32'(xr_n[0] - base_x0), 32'd8);
        waitWrites(6, "t3 second write");
        checkOutput("t3 second tag", 32'(wr_tag[5]), 32'd1);
        checkOutput("t3 second y", 32'(wr_y[5]), 32'd100);

        // acc = 271 -> (271+32)>>6 = 4; x stalls after 3 samples, output blocked by full.
        y_full = 2'b01;
        base_x0 = xr_n[0];
        base_w = wr_n;
        applyStimulus(0, '{-1, 4, -10, 58, 17, -5, 1, 0}, stall_x, 3);
        waitXReads(0, base_x0 + 3, "t4 first three");
        repeat (5) @(negedge clk);
        #1;
        checkOutput("t4 stall no read", 32'(x_read), 32'd0);
        checkOutput("t4 stall count", 32'(xr_n[0] - base_x0), 32'd3);
        pushSamples(0, stall_x, 3, 5);
        waitXReads(0, base_x0 + 8, "t4 all eight");
        for (int i = 0; i < 4; i++) begin
            #1;
            checkOutput("t4 full no write", 32'(y_write), 32'd0);
            checkOutput("t4 full din held", 32'(y_din), 32'h004);
            @(negedge clk);
        end
        checkOutput("t4 nothing logged", 32'(wr_n - base_w), 32'd0);
        y_full = 2'b00;
        #1;
        checkOutput("t4 write on release", 32'(y_write), 32'd1);
        waitWrites(base_w + 1, "t4 write");
        checkOutput("t4 tag", 32'(wr_tag[base_w]), 32'd0);
        checkOutput("t4 y", 32'(wr_y[base_w]), 32'd4);
        repeat (3) @(negedge clk);
        checkOutput("t4 single write", 32'(wr_n - base_w), 32'd1);

        // Same set without stalls on tag 1 gives the same sample.
        applyStimulus(1, '{-1, 4, -10, 58, 17, -5, 1, 0}, stall_x, 8);
        waitWrites(base_w + 2, "t5 write");
        checkOutput("t5 tag", 32'(wr_tag[base_w + 1]), 32'd1);
        checkOutput("t5 y", 32'(wr_y[base_w + 1]), 32'd4);

        // Abort at idx=4; the fresh set must show no trace of 4*8*200.
        base_w = wr_n;
        base_x0 = xr_n[0];
        applyStimulus(0, '{8, 8, 8, 8, 8, 8, 8, 8}, '{200, 200, 200, 200, 0, 0, 0, 0}, 4);
        waitXReads(0, base_x0 + 4, "t6 four reads");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        applyStimulus(0, '{0, 0, 0, 64, 0, 0, 0, 0}, '{30, 31, 32, 33, 34, 35, 36, 37}, 8);
        #1;
        checkOutput("t6 rst c_read", 32'(c_read[0]), 32'd0);
        checkOutput("t6 rst c7_read", 32'(c_read[7]), 32'd0);
        checkOutput("t6 rst x_read", 32'(x_read), 32'd0);
        checkOutput("t6 rst write", 32'(y_write), 32'd0);
        checkOutput("t6 rst din", 32'(y_din), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        base_x0 = xr_n[0];
        waitWrites(base_w + 1, "t6 write");
        checkOutput("t6 tag", 32'(wr_tag[base_w]), 32'd0);
        checkOutput("t6 y fresh", 32'(wr_y[base_w]), 32'd33);
        checkOutput("t6 x reads", 32'(xr_n[0] - base_x0), 32'd8);

        repeat (3) @(negedge clk);
        checkOutput("c-port read agreement", 32'(cmis), 32'd0);
        checkOutput("protocol violations", 32'(bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
